// File: rtl/alu_pkg.sv
// Shared ALU definitions: the bitwise op encoding used by the ALU top-level
// decoder and the result stage, plus the default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_XNOR = 3'd4,
        OP_NOR  = 3'd5,
        OP_NOTA = 3'd6,
        OP_NOTB = 3'd7
    } alu_op_e;

endpackage

// File: rtl/bitwise_sel8.sv
// Combinational 8:1 select of the bitwise operator results by op, plus the
// zero / parity / msb flags of the selected value.
//   op                        : operation select (alu_op_e encoding)
//   and8..notb                : candidate results, WIDTH bits each
//   sel                       : selected result
//   zero / parity / msb       : sel == 0, ^sel, sel[WIDTH-1]
module bitwise_sel8
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] and8,
    input  logic [WIDTH-1:0] nand8,
    input  logic [WIDTH-1:0] or8,
    input  logic [WIDTH-1:0] xor8,
    input  logic [WIDTH-1:0] xnor8,
    input  logic [WIDTH-1:0] nor8,
    input  logic [WIDTH-1:0] nota,
    input  logic [WIDTH-1:0] notb,
    output logic [WIDTH-1:0] sel,
    output logic             zero,
    output logic             parity,
    output logic             msb
);

    always_comb begin
        sel = '0;
        case (op)
            OP_AND:  sel = and8;
            OP_NAND: sel = nand8;
            OP_OR:   sel = or8;
            OP_XOR:  sel = xor8;
            OP_XNOR: sel = xnor8;
            OP_NOR:  sel = nor8;
            OP_NOTA: sel = nota;
            OP_NOTB: sel = notb;
            default: sel = '0;
        endcase
    end

    assign zero   = (sel == '0);
    assign parity = ^sel;
    assign msb    = sel[WIDTH-1];

endmodule

// File: rtl/bitwise_result_stage.sv
// Two-entry result buffer behind the bitwise operator stage. On a push the
// result chosen by op is captured with its op and flags; the head entry is
// presented downstream with a valid/ready handshake. xfer_cnt counts pops.
//   clk, rst_n                : clock, async active-low reset
//   in_valid/in_ready, op     : upstream handshake and op select
//   and8..notB                : bitwise results, WIDTH bits each
//   out_valid/out_ready       : downstream handshake
//   result, op_q, zero,
//   parity, msb               : head entry contents
//   xfer_cnt                  : completed output transfers, wraps at 16 bits
module bitwise_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 2          // only 2 is supported (1-bit pointers)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] and8,
    input  logic [WIDTH-1:0] nand8,
    input  logic [WIDTH-1:0] or8,
    input  logic [WIDTH-1:0] xor8,
    input  logic [WIDTH-1:0] xnor8,
    input  logic [WIDTH-1:0] nor8,
    input  logic [WIDTH-1:0] notA,
    input  logic [WIDTH-1:0] notB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       op_q,
    output logic             zero,
    output logic             parity,
    output logic             msb,
    output logic [15:0]      xfer_cnt
);

    logic [WIDTH-1:0] sel;
    logic             sel_zero, sel_parity, sel_msb;

    bitwise_sel8 #(.WIDTH(WIDTH)) u_sel (
        .op     (op),
        .and8   (and8),
        .nand8  (nand8),
        .or8    (or8),
        .xor8   (xor8),
        .xnor8  (xnor8),
        .nor8   (nor8),
        .nota   (notA),
        .notb   (notB),
        .sel    (sel),
        .zero   (sel_zero),
        .parity (sel_parity),
        .msb    (sel_msb)
    );

    logic [WIDTH-1:0] res_mem [DEPTH];
    logic [2:0]       op_mem  [DEPTH];
    logic             zero_mem[DEPTH];
    logic             par_mem [DEPTH];
    logic             msb_mem [DEPTH];

    logic        rd_ptr, wr_ptr;
    logic [1:0]  count, count_nxt;
    logic        rdy_q;
    logic [15:0] xfer_q;
    logic        push, pop;

    // in_ready is a flop rather than decode of count so it stays low through
    // reset and rises only on the first edge after release.
    assign push = in_valid && rdy_q;
    assign pop  = (count != 2'd0) && out_ready;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            rdy_q  <= 1'b0;
            xfer_q <= 16'd0;
            // Cleared entries make the head read as result 0 with zero set.
            for (int i = 0; i < DEPTH; i++) begin
                res_mem[i]  <= '0;
                op_mem[i]   <= 3'd0;
                zero_mem[i] <= 1'b1;
                par_mem[i]  <= 1'b0;
                msb_mem[i]  <= 1'b0;
            end
        end else begin
            count <= count_nxt;
            rdy_q <= (count_nxt < 2'(DEPTH));
            if (push) begin
                res_mem[wr_ptr]  <= sel;
                op_mem[wr_ptr]   <= op;
                zero_mem[wr_ptr] <= sel_zero;
                par_mem[wr_ptr]  <= sel_parity;
                msb_mem[wr_ptr]  <= sel_msb;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                xfer_q <= xfer_q + 16'd1;
            end
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (count != 2'd0);
    assign result    = res_mem[rd_ptr];
    assign op_q      = op_mem[rd_ptr];
    assign zero      = zero_mem[rd_ptr];
    assign parity    = par_mem[rd_ptr];
    assign msb       = msb_mem[rd_ptr];
    assign xfer_cnt  = xfer_q;

endmodule

// File: doc/bitwise_result_stage.md
BITWISE_RESULT_STAGE -- requirements
Module: bitwise_result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, result buffer entries; only the value 2 is supported.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream holds a valid op plus bitwise results.
REQ-006 SHALL have port in_ready, output, 1, stage can accept this cycle.
REQ-007 SHALL have port op, input, 3, select: 0 AND, 1 NAND, 2 OR, 3 XOR, 4 XNOR, 5 NOR, 6 NOTA, 7 NOTB.
REQ-008 SHALL have ports and8, nand8, or8, xor8, xnor8, nor8, notA, notB, input, WIDTH each, results from the bitwise operator stage.
REQ-009 SHALL have port out_valid, output, 1, head entry valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the head entry.
REQ-011 SHALL have port result, output, WIDTH, head entry result.
REQ-012 SHALL have port op_q, output, 3, op that produced the head result.
REQ-013 SHALL have port zero, output, 1, high when head result == 0.
REQ-014 SHALL have port parity, output, 1, XOR-reduction of the head result.
REQ-015 SHALL have port msb, output, 1, equal to the head result bit WIDTH-1.
REQ-016 SHALL have port xfer_cnt, output, 16, count of completed output transfers.

Function
REQ-017 SHALL define push as in_valid && in_ready and pop as out_valid && out_ready.
REQ-018 SHALL on push select the input bus indexed by op, compute zero/parity/msb, and write {result, op, flags} into the tail entry.
REQ-019 SHALL drive in_ready = (count < 2) from registered state only, with no combinational path from out_ready.
REQ-020 SHALL drive out_valid = (count != 0) and present the head entry on result, op_q and the flags.
REQ-021 SHALL have a latency of 1 cycle: a push at edge N with count 0 makes out_valid high after edge N.
REQ-022 SHALL update the count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop (count 1); the head then advances and the new entry is written.
REQ-023 SHALL use 1-bit read and write pointers that wrap modulo 2.
REQ-024 SHALL hold in_ready low at count 2; in_valid is then ignored.
REQ-025 SHALL ignore out_ready at count 0, with no pointer or counter change.
REQ-026 SHALL hold head outputs stable while out_valid && !out_ready.
REQ-027 SHALL increment xfer_cnt by 1 on each pop, wrapping 0xFFFF to 0x0000.
REQ-028 SHALL treat the entry contents as don't-care when out_valid is low, but the bench checks only the reset values.

Reset
REQ-029 SHALL on rst_n low immediately clear count, the pointers and xfer_cnt, giving out_valid 0 and in_ready 0 while rst_n is low.
REQ-030 SHALL drive result, op_q, zero, parity and msb to 0, 0, 1, 0 and 0 while reset is asserted; the zero value reflects the cleared entry.
REQ-031 SHALL discard buffered entries when reset is asserted mid-operation, with no pop counted.
REQ-032 SHALL raise in_ready on the first rising clk edge after rst_n is released.

Structure
REQ-033 SHALL place the op encoding constants (OP_AND..OP_NOTB) and the default WIDTH in shared package alu_pkg, for use by the ALU top-level decoder.
REQ-034 SHALL implement the 8:1 result select plus flag generation as one combinational sub-module, bitwise_sel8; the buffer and counters stay in bitwise_result_stage.

Verification
REQ-035 SHALL verify that reset asserted with two entries held gives out_valid 0, xfer_cnt 0 and zero 1, and that in_ready is 1 one clock after release.
REQ-036 SHALL verify that op=3 with xor8=0xCC, out_ready=1 gives result 0xCC, parity 0, msb 1 and zero 0 one cycle later, with xfer_cnt 1.
REQ-037 SHALL verify that op=0 with and8=0x00 gives zero 1, and that op=6 with notA=0x01 gives parity 1 and msb 0.
REQ-038 SHALL verify that with out_ready=0 and three back-to-back pushes (0x11, 0x22, 0x33), in_ready falls after the second push, the third is not accepted, and the head holds 0x11.
REQ-039 SHALL verify that at count 1, simultaneous push 0x44 and pop 0x11 leave the count at 1 with the head 0x44 next cycle.
REQ-040 SHALL verify that 65536 pops bring xfer_cnt back to 0x0000.
